// File: rtl/q49_sweep_checker.sv
// q49_sweep_checker
// Clocked, restartable stimulus-and-capture sweep for the Q49 two-output
// combinational block. It drives {A,B,C,D} through codes 0..15 and holds
// each code for dwell+1 clock edges before sampling it. The returned F1/F2
// values are captured into two 16-bit truth tables. Codes whose F1 or F2
// differs from the expected mask are counted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a sweep (honoured only when idle)
//   dwell        extra settle cycles per code, latched on start accept
//   f1_in/f2_in  outputs returned from the Q49 block
//   abcd_out     registered {A,B,C,D} stimulus
//   busy         high while a sweep is in progress
//   done         one-cycle pulse when the sweep completes
//   tt_f1/tt_f2  captured truth tables (bit i = response to code i)
//   mismatch_cnt number of codes (0..16) with any mismatching output
//   pass         last completed sweep had no mismatches
module q49_sweep_checker #(
  parameter int unsigned DWELL_W = 4,
  parameter logic [15:0] EXP_F1  = 16'hFF5E,
  parameter logic [15:0] EXP_F2  = 16'h55F5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               f1_in,
  input  logic               f2_in,
  output logic [3:0]         abcd_out,
  output logic               busy,
  output logic               done,
  output logic [15:0]        tt_f1,
  output logic [15:0]        tt_f2,
  output logic [4:0]         mismatch_cnt,
  output logic               pass
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned TT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   abcd_q, abcd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TT_W-1:0]    tt_f1_q, tt_f1_d;
  logic [TT_W-1:0]    tt_f2_q, tt_f2_d;
  logic [CNT_W-1:0]   mismatch_q, mismatch_d;
  logic               pass_q, pass_d;
  logic               code_miss;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      abcd_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      dwell_lat_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tt_f1_q     <= '0;
      tt_f2_q     <= '0;
      mismatch_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      abcd_q      <= abcd_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dwell_lat_q <= dwell_lat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tt_f1_q     <= tt_f1_d;
      tt_f2_q     <= tt_f2_d;
      mismatch_q  <= mismatch_d;
      pass_q      <= pass_d;
    end
  end

  // A code counts once even when both outputs disagree
  always_comb begin
    code_miss = (f1_in != EXP_F1[idx_q]) || (f2_in != EXP_F2[idx_q]);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    abcd_d      = abcd_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dwell_lat_d = dwell_lat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tt_f1_d     = tt_f1_q;
    tt_f2_d     = tt_f2_q;
    mismatch_d  = mismatch_q;
    pass_d      = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          abcd_d      = '0;
          idx_d       = '0;
          cnt_d       = dwell;
          dwell_lat_d = dwell;
          tt_f1_d     = '0;
          tt_f2_d     = '0;
          mismatch_d  = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          // Sample edge for the current code
          tt_f1_d[idx_q] = f1_in;
          tt_f2_d[idx_q] = f2_in;
          if (code_miss) begin
            mismatch_d = mismatch_q + CNT_W'(1);
          end
          if (idx_q == IDX_W'(15)) begin
            // Last code: abcd_out stays at 4'hF until the next start
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mismatch_d == '0);
            state_d = DONE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            abcd_d = idx_q + IDX_W'(1);
            cnt_d  = dwell_lat_q;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign abcd_out     = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt_f1        = tt_f1_q;
  assign tt_f2        = tt_f2_q;
  assign mismatch_cnt = mismatch_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_q49_sweep_checker.sv
// Testbench for q49_sweep_checker: a behavioural Q49 stand-in answers each
// code from a programmable truth table. Expected results are derived from
// that table, the golden masks and the dwell value.
module tb_q49_sweep_checker;

  localparam logic [15:0] EXP1 = 16'hFF5E;
  localparam logic [15:0] EXP2 = 16'h55F5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dwell = 4'd0;
  logic        f1_in;
  logic        f2_in;
  logic [3:0]  abcd_out;
  logic        busy;
  logic        done;
  logic [15:0] tt_f1;
  logic [15:0] tt_f2;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  // Truth tables currently implemented by the stand-in Q49 block
  logic [15:0] q1 = EXP1;
  logic [15:0] q2 = EXP2;

  int n_vec = 0;
  int n_err = 0;

  int abcd_tr[$];
  int busy_tr[$];

  assign f1_in = q1[abcd_out];
  assign f2_in = q2[abcd_out];

  always #5 clk = ~clk;

  q49_sweep_checker #(
    .DWELL_W(4),
    .EXP_F1 (EXP1),
    .EXP_F2 (EXP2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dwell        (dwell),
    .f1_in        (f1_in),
    .f2_in        (f2_in),
    .abcd_out     (abcd_out),
    .busy         (busy),
    .done         (done),
    .tt_f1        (tt_f1),
    .tt_f2        (tt_f2),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  // Number of codes where either table deviates from the golden masks
  function automatic int model_miss(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] diff;
    int n;
    diff = (a ^ EXP1) | (b ^ EXP2);
    n = 0;
    for (int i = 0; i < 16; i++) if (diff[i]) n++;
    return n;
  endfunction

  // Launch a sweep and record abcd_out/busy after every edge (entry 0 is
  // right after the start-accept edge). Optionally re-pulses start at code 7.
  task automatic run_sweep(input int d, input bit poke, output int done_at,
                           output int ndone);
    bit poked;
    poked   = 1'b0;
    done_at = -1;
    ndone   = 0;
    abcd_tr.delete();
    busy_tr.delete();
    dwell = 4'(d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dwell = 4'($urandom);
    abcd_tr.push_back(int'(abcd_out));
    busy_tr.push_back(int'(busy));
    for (int c = 1; c <= 600; c++) begin
      if (poke && !poked && abcd_out == 4'd7) begin
        start = 1'b1;
        dwell = 4'($urandom);
        poked = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abcd_tr.push_back(int'(abcd_out));
      busy_tr.push_back(int'(busy));
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({abcd_out, busy, done, tt_f1, tt_f2, mismatch_cnt, pass} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: abcd=%h busy=%b done=%b tt1=%h tt2=%h cnt=%0d pass=%b, required all zero",
               abcd_out, busy, done, tt_f1, tt_f2, mismatch_cnt, pass);
    end
  endtask

  // One complete sweep with a given dwell and Q49 behaviour
  task automatic test_sweep(input string name, input int d,
                            input logic [15:0] t1, input logic [15:0] t2);
    int da, nd, len, bad, first_bad, em;
    q1 = t1;
    q2 = t2;
    run_sweep(d, 1'b0, da, nd);
    len = 16 * (d + 1);
    em  = model_miss(t1, t2);

    n_vec++;
    if (da !== len) begin
      n_err++;
      $display("FAIL %s done_time: got %0d cycles, required %0d", name, da, len);
    end
    n_vec++;
    if (nd !== 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, nd);
    end
    bad = 0;
    first_bad = -1;
    for (int c = 0; c < abcd_tr.size(); c++) begin
      int ea, eb;
      ea = (c < len) ? c / (d + 1) : 15;
      eb = (c < len) ? 1 : 0;
      if (abcd_tr[c] != ea || busy_tr[c] != eb) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s abcd_busy_trace: %0d bad cycles, first at %0d (abcd=%0d busy=%0d), required abcd=%0d busy=%0d",
               name, bad, first_bad, abcd_tr[first_bad], busy_tr[first_bad],
               (first_bad < len) ? first_bad / (d + 1) : 15, (first_bad < len) ? 1 : 0);
    end
    n_vec++;
    if (tt_f1 !== t1) begin
      n_err++;
      $display("FAIL %s tt_f1: got %h, required %h", name, tt_f1, t1);
    end
    n_vec++;
    if (tt_f2 !== t2) begin
      n_err++;
      $display("FAIL %s tt_f2: got %h, required %h", name, tt_f2, t2);
    end
    n_vec++;
    if (mismatch_cnt !== 5'(em)) begin
      n_err++;
      $display("FAIL %s mismatch_cnt: got %0d, required %0d", name, mismatch_cnt, em);
    end
    n_vec++;
    if (pass !== (em == 0)) begin
      n_err++;
      $display("FAIL %s pass: got %b, required %b", name, pass, (em == 0));
    end
  endtask

  // start pulsed at code 7 must not restart or queue a sweep
  task automatic test_mid_start();
    int da, nd;
    q1 = EXP1;
    q2 = EXP2;
    run_sweep(1, 1'b1, da, nd);
    n_vec++;
    if (da !== 32) begin
      n_err++;
      $display("FAIL mid_start done_time: got %0d, required 32", da);
    end
    n_vec++;
    if (nd !== 1) begin
      n_err++;
      $display("FAIL mid_start done_pulses: got %0d, required 1", nd);
    end
    n_vec++;
    if (busy !== 1'b0 || abcd_out !== 4'hF) begin
      n_err++;
      $display("FAIL mid_start idle_after: busy=%b abcd=%h, required busy=0 abcd=f", busy, abcd_out);
    end
    n_vec++;
    if (pass !== 1'b1 || mismatch_cnt !== 5'd0) begin
      n_err++;
      $display("FAIL mid_start result: pass=%b cnt=%0d, required pass=1 cnt=0", pass, mismatch_cnt);
    end
  endtask

  // Asynchronous reset between edges while code 9 is being driven
  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    q1 = EXP1;
    q2 = 16'h0000;
    dwell = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (abcd_out == 4'd9) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL async_reset reach_code9: timed out, abcd=%0d required 9", abcd_out);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({abcd_out, busy, done, tt_f1, tt_f2, mismatch_cnt, pass} !== '0) begin
      n_err++;
      $display("FAIL async_reset immediate: abcd=%h busy=%b done=%b tt1=%h tt2=%h cnt=%0d pass=%b, required all zero",
               abcd_out, busy, done, tt_f1, tt_f2, mismatch_cnt, pass);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || abcd_out !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset stays_idle: busy=%b abcd=%h, required busy=0 abcd=0", busy, abcd_out);
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_sweep("dwell0", 0, EXP1, EXP2);
    test_sweep("dwell3", 3, EXP1, EXP2);
    test_sweep("f1_stuck0", 0, 16'h0000, EXP2);
    test_sweep("f2_inverted", 2, EXP1, ~EXP2);
    test_sweep("dwell_max", 15, EXP1, EXP2);
    test_mid_start();
    test_sweep("restart_after_done", 0, 16'h0000, EXP2);
    test_async_reset();
    test_sweep("after_reset", 1, EXP1, EXP2);

    for (int k = 0; k < 6; k++) begin
      int d;
      logic [15:0] m1, m2;
      d  = int'($urandom_range(0, 6));
      m1 = (k % 3 == 0) ? 16'h0000 : 16'($urandom);
      m2 = (k % 2 == 0) ? 16'h0000 : 16'($urandom);
      test_sweep("random", d, EXP1 ^ m1, EXP2 ^ m2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
